// File: rtl/itcm_fetch_slave.sv
// Instruction TCM answering IFU fetches with one-cycle registered read latency,
// plus a byte-serial loader that assembles little-endian words from address 0.
module itcm_fetch_slave #(
    parameter int unsigned AW  = 10,
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_vld,
    input  logic [31:0]   pc_ram,
    output logic [31:0]   pre_instr,
    output logic          fetch_err,
    output logic          core_hold,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_words
);

    typedef enum logic [1:0] {RUN, LOAD, RESUME} state_t;

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] WORDS_MAX = {1'b1, {AW{1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     words_q, words_d;
    logic [31:0]     asm_q, asm_d;
    logic            rd_ok_q, rd_ok_d;
    logic            err_q, err_d;
    logic            hold_q, hold_d;
    logic            rdy_q, rdy_d;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_data_q;
    logic [31:0]     wdata;
    logic            we;
    logic            re;
    logic            pc_bad;
    logic            accept;

    assign pc_bad = (pc_ram[1:0] != 2'b00) || (pc_ram[31:AW+2] != '0);
    assign accept = (state_q == LOAD) && ld_valid && rdy_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wptr_d     = wptr_q;
        words_d    = words_q;
        asm_d      = asm_q;
        rd_ok_d    = 1'b0;
        err_d      = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        // The assembly buffer is cleared after every write, so lanes above the
        // current byte are already zero when ld_last closes a partial word.
        wdata      = asm_q | (32'(ld_byte) << {byte_cnt_q, 3'b000});

        unique case (state_q)
            RUN: begin
                if (pc_vld) begin
                    re      = !pc_bad;
                    rd_ok_d = !pc_bad;
                    err_d   = pc_bad;
                end
                if (ld_valid) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    wptr_d     = '0;
                    words_d    = '0;
                    asm_d      = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if ((byte_cnt_q == 2'd3) || ld_last) begin
                        we      = 1'b1;
                        wptr_d  = wptr_q + AW'(1);
                        words_d = (words_q == WORDS_MAX) ? words_q : words_q + (AW+1)'(1);
                        asm_d   = '0;
                    end else begin
                        asm_d = wdata;
                    end
                    if (ld_last) begin
                        state_d    = RESUME;
                        byte_cnt_d = '0;
                    end
                end
            end
            RESUME: state_d = RUN;
            default: state_d = RUN;
        endcase

        hold_d = (state_d != RUN);
        rdy_d  = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            byte_cnt_q <= '0;
            wptr_q     <= '0;
            words_q    <= '0;
            asm_q      <= '0;
            rd_ok_q    <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wptr_q     <= wptr_d;
            words_q    <= words_d;
            asm_q      <= asm_d;
            rd_ok_q    <= rd_ok_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            rdy_q      <= rdy_d;
        end
    end

    // Writes happen only in LOAD and reads only in RUN, so one port is shared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr_q] <= wdata;
        end else if (re) begin
            rd_data_q <= mem[pc_ram[AW+1:2]];
        end
    end

    assign pre_instr = rd_ok_q ? rd_data_q : NOP;
    assign fetch_err = err_q;
    assign core_hold = hold_q;
    assign ld_ready  = rdy_q;
    assign ld_words  = words_q;

endmodule

// File: tb/tb_itcm_fetch_slave.sv
// Scoreboard bench for itcm_fetch_slave: loads images through the byte port and
// checks fetch responses against a bench-side memory model.
module tb_itcm_fetch_slave;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_vld;
    logic [31:0]   pc_ram;
    logic [31:0]   pre_instr;
    logic          fetch_err;
    logic          core_hold;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic [AW:0]   ld_words;

    itcm_fetch_slave #(.AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .pc_vld(pc_vld), .pc_ram(pc_ram),
        .pre_instr(pre_instr), .fetch_err(fetch_err), .core_hold(core_hold),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_words(ld_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] ref_mem [DEPTH];
    int          m_cnt;
    int          m_wptr;
    int          m_words;
    logic [31:0] m_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_start();
        m_cnt   = 0;
        m_wptr  = 0;
        m_words = 0;
        m_word  = 32'h0;
    endtask

    task automatic model_accept(input logic [7:0] b, input bit last);
        m_word[m_cnt*8 +: 8] = b;
        if (m_cnt == 3 || last) begin
            ref_mem[m_wptr] = m_word;
            m_wptr  = (m_wptr + 1) % DEPTH;
            m_words = (m_words < DEPTH) ? m_words + 1 : m_words;
            m_word  = 32'h0;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was handshaked.
    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        int n;
        repeat (gap) begin
            ld_valid = 1'b0;
            @(negedge clk);
            check("ready_in_gap", ld_ready, 1);
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        n = 0;
        while (!ld_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) check("ready_timeout", 0, 1);
        check("hold_in_load", core_hold, 1);
        check("nop_in_load", pre_instr, NOP);
        @(negedge clk);
        model_accept(b, last);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_image(input logic [7:0] img[$], input bit with_last, input int gap_max);
        model_start();
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], with_last && (i == img.size() - 1),
                      (i == 0) ? 0 : $urandom_range(gap_max, 0));
        end
        if (with_last) begin
            check("resume_hold", core_hold, 1);
            check("resume_ready", ld_ready, 0);
            check("resume_nop", pre_instr, NOP);
            check("ld_words", ld_words, m_words);
            @(negedge clk);
            check("run_hold", core_hold, 0);
            check("run_ready", ld_ready, 0);
        end
    endtask

    // Back-to-back requests; each response is compared one cycle later.
    task automatic fetch_seq(input logic [31:0] addrs[$], input bit vld[$]);
        exp_t e;
        exp_t r;
        for (int i = 0; i <= addrs.size(); i++) begin
            if (i > 0) begin
                r = sb.pop_front();
                check($sformatf("instr@%0h", r.addr), pre_instr, r.instr);
                check($sformatf("err@%0h", r.addr), fetch_err, r.err);
            end
            if (i < addrs.size()) begin
                pc_vld = vld[i];
                pc_ram = addrs[i];
                e.addr = addrs[i];
                if (!vld[i]) begin
                    e.instr = NOP; e.err = 1'b0;
                end else if (addrs[i][1:0] != 2'b00 || addrs[i][31:AW+2] != '0) begin
                    e.instr = NOP; e.err = 1'b1;
                end else begin
                    e.instr = ref_mem[addrs[i][AW+1:2]]; e.err = 1'b0;
                end
                sb.push_back(e);
                @(negedge clk);
            end
        end
        pc_vld = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  img[$];
        logic [31:0] adr[$];
        bit          vl[$];

        rst = 1'b1; pc_vld = 1'b0; pc_ram = '0;
        ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_instr", pre_instr, NOP);
        check("rst_err", fetch_err, 0);
        check("rst_hold", core_hold, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_words", ld_words, 0);
        rst = 1'b0;
        @(negedge clk);

        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        load_image(img, 1, 0);
        check("img1_w0", ref_mem[0], 32'h00100513);
        adr = '{32'h0, 32'h4, 32'h2, 32'h1000, 32'h0, 32'h4};
        vl  = '{1, 1, 1, 1, 0, 1};
        fetch_seq(adr, vl);

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_image(img, 1, 0);
        adr = '{32'h4, 32'h0, 32'h8000_0000, 32'h7};
        vl  = '{1, 1, 1, 1};
        fetch_seq(adr, vl);

        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load_image(img, 0, 3);
        rst = 1'b1;
        #1;
        check("async_rst_hold", core_hold, 0);
        check("async_rst_ready", ld_ready, 0);
        check("async_rst_words", ld_words, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_hold", core_hold, 0);
        adr = '{32'h0, 32'h4};
        vl  = '{1, 1};
        fetch_seq(adr, vl);

        img = {};
        for (int i = 0; i < (DEPTH + 1) * 4; i++) img.push_back(8'($urandom));
        load_image(img, 1, 0);
        check("wrap_words", ld_words, DEPTH);
        adr = '{32'h0, 32'h4, 32'hFFC, 32'h800};
        vl  = '{1, 1, 1, 1};
        fetch_seq(adr, vl);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/itcm_fetch_slave.md
Name: itcm_fetch_slave

Overview:
- Instruction tightly-coupled memory. Acts as the responder on the fetch-side PC/instruction interface driven by the IFU.
- Returns the instruction word at the requested PC with one cycle of registered read latency.
- Has a byte-serial loader port with valid/ready handshake. It assembles little-endian words and writes them from address 0; the core is held with NOPs while a load is in progress.

Parameters:
- AW, 10, word-address width; memory depth is 2**AW words (4 KiB at default).
- NOP, 32'h00000013, instruction returned on hold, error or reset (addi x0,x0,0).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- pc_vld  input  1  fetch request valid this cycle.
- pc_ram  input  32  fetch byte address.
- pre_instr  output  32  instruction for the request made in the previous cycle.
- fetch_err  output  1  one-cycle pulse aligned with pre_instr; previous request was misaligned or out of range.
- core_hold  output  1  high while not in RUN; core must stall/flush.
- ld_valid  input  1  loader byte valid.
- ld_byte  input  8  loader data byte.
- ld_last  input  1  marks final byte of image; qualified by ld_valid&ld_ready.
- ld_ready  output  1  loader byte accepted when ld_valid&ld_ready.
- ld_words  output  AW+1  words written by the current/last load.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All state clears on rst assertion regardless of clock.
- Reset values: state=RUN, pre_instr=NOP, fetch_err=0, core_hold=0, ld_ready=0, ld_words=0, byte counter=0. Memory array is not reset.
- States: RUN, LOAD, RESUME.
- RUN:
  - ld_ready=0.
  - On a cycle with pc_vld=1, index=pc_ram[AW+1:2] is registered and pre_instr=mem[index] on the next cycle.
  - If pc_ram[1:0]!=0 or pc_ram[31:AW+2]!=0: next-cycle pre_instr=NOP and fetch_err=1.
  - pc_vld=0: next-cycle pre_instr=NOP, fetch_err=0.
  - ld_valid=1 (any byte) moves to LOAD next cycle. That byte is NOT consumed. ld_words, byte counter and write pointer clear on entry.
- LOAD:
  - core_hold=1, ld_ready=1, pre_instr=NOP from the first LOAD cycle onward; fetch requests are ignored.
  - Each accepted byte goes to lane byte_cnt (byte 0 = bits 7:0); byte_cnt increments mod 4.
  - When byte_cnt==3 on accept: the full word is written to mem[wptr], wptr++, ld_words++.
  - wptr wraps 2**AW-1 -> 0, overwriting silently. ld_words saturates at 2**AW.
  - Accepted byte with ld_last=1: the current word is written with unfilled upper lanes zero-padded (a no-op if byte_cnt was 3, since the write already occurs). Then go to RESUME.
- RESUME:
  - Exactly one cycle. core_hold=1, ld_ready=0, pre_instr=NOP. Then RUN.
  - The first fetch response after RESUME is for a request made in RUN.
- Memory write and read never occur in the same cycle, so a single-port array is required to suffice.
- Simultaneous events:
  - ld_valid rising in the same cycle as pc_vld in RUN: the fetch is serviced normally. The LOAD-entry NOP starts the cycle after.
  - rst mid-LOAD: load aborts, partially assembled word is discarded, state RUN. Already-written words remain.

Test Plan:
- Reset, then load 8 bytes 13 05 10 00 93 05 20 00 with ld_last on the 8th -> ld_words=2, mem[0]=32'h00100513, mem[1]=32'h00200593, core_hold high from LOAD entry through RESUME, one RESUME cycle.
- After the load, pc_vld=1 with pc_ram=0 then 4 -> pre_instr=32'h00100513 then 32'h00200593, each one cycle later; fetch_err=0.
- pc_ram=32'h2 -> next cycle pre_instr=NOP, fetch_err=1. pc_ram=32'h1000 (AW=10) -> NOP, fetch_err=1.
- Load 5 bytes AA BB CC DD EE, last on EE -> mem[0]=32'hDDCCBBAA, mem[1]=32'h000000EE, ld_words=2.
- Loader drives ld_valid with random gaps -> only handshaked bytes counted; ld_ready held 1 throughout LOAD. Assert rst after 6 bytes -> state RUN, core_hold=0, mem[0] kept, mem[1] unchanged.
- Load 2**AW+1 words -> wptr wraps, mem[0] holds the last word, ld_words=2**AW.
